// File: rtl/fadder_1_beh.sv
// Single-bit full adder: combinational sum/carry plus a registered copy of both
// for downstream synchronous logic.
module fadder_1_beh (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c,
  input  logic clk,
  input  logic rst_n,
  output logic s_q,
  output logic c_q
);

  logic [1:0] total;

  // Operands are widened so the carry survives the addition.
  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {1'b0, z};
    s     = total[0];
    c     = total[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      s_q <= s;
      c_q <= c;
    end
  end

endmodule

// File: tb/tb_fadder_1_beh.sv
// Scoreboard bench for fadder_1_beh: stimulus queues expected outputs, a
// separate monitor samples the DUT and compares against the queue.
module tb_fadder_1_beh;

  logic clk, rst_n, x, y, z;
  logic s, c, s_q, c_q;

  fadder_1_beh dut (
    .x(x), .y(y), .z(z), .s(s), .c(c),
    .clk(clk), .rst_n(rst_n), .s_q(s_q), .c_q(c_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed/expected vectors are packed as {s, c, s_q, c_q}.
  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [3:0] exp;
  } exp_t;

  localparam logic [3:0] M_COMB = 4'b1100;
  localparam logic [3:0] M_REG  = 4'b0011;
  localparam logic [3:0] M_ALL  = 4'b1111;

  exp_t sb_q[$];
  event sample_ev;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_out(input string name, input logic [3:0] mask,
                            input logic [3:0] exp);
    exp_t e;
    e.name = name;
    e.mask = mask;
    e.exp  = exp;
    sb_q.push_back(e);
    -> sample_ev;
  endtask

  // Monitor: drains every pending expectation against the current outputs.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        exp_t       e;
        logic [3:0] obs;
        e   = sb_q.pop_front();
        obs = {s, c, s_q, c_q};
        n_vec++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          n_err++;
          $display("FAIL %s: got {s,c,s_q,c_q}=%b required %b (mask %b) at t=%0t",
                   e.name, obs, e.exp, e.mask, $time);
        end
      end
    end
  end

  logic [2:0] sweep_in  [8] = '{3'b000, 3'b100, 3'b010, 3'b110,
                                3'b001, 3'b101, 3'b011, 3'b111};
  logic [1:0] sweep_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01,
                                2'b10, 2'b01, 2'b01, 2'b11};   // {s, c}
  logic [2:0] sym_in    [6] = '{3'b100, 3'b010, 3'b001,
                                3'b110, 3'b101, 3'b011};

  initial begin
    rst_n = 1'b0;
    {x, y, z} = 3'b000;
    #2;
    expect_out("reset_000", M_ALL, 4'b0000);
    #1;
    {x, y, z} = 3'b111;
    #1;
    expect_out("comb_in_reset", M_ALL, 4'b1100);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, 4 time units per vector, sampled mid-interval.
    for (int i = 0; i < 8; i++) begin
      {x, y, z} = sweep_in[i];
      #2;
      expect_out($sformatf("sweep_%b", sweep_in[i]), M_COMB,
                 {sweep_exp[i], 2'b00});
      #2;
    end

    @(negedge clk);
    {x, y, z} = 3'b110;
    @(posedge clk);
    #1;
    expect_out("reg_110", M_ALL, 4'b0101);

    @(negedge clk);
    {x, y, z} = 3'b111;
    @(posedge clk);
    #1;
    expect_out("reg_111", M_ALL, 4'b1111);

    #2;
    {x, y, z} = 3'b101;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", M_ALL, 4'b0100);
    @(posedge clk);
    #1;
    expect_out("hold_in_reset", M_ALL, 4'b0100);

    @(negedge clk);
    {x, y, z} = 3'b100;
    rst_n = 1'b1;
    #1;
    expect_out("release_no_capture", M_ALL, 4'b1000);
    @(posedge clk);
    #1;
    expect_out("release_first_edge", M_ALL, 4'b1010);

    @(negedge clk);
    {x, y, z} = 3'b000;
    @(posedge clk);
    // Scheduled as an update so the flops see the pre-edge 000.
    {x, y, z} <= 3'b111;
    #1;
    expect_out("same_edge_old", M_ALL, 4'b1100);
    @(posedge clk);
    #1;
    expect_out("same_edge_new", M_ALL, 4'b1111);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {x, y, z} = sym_in[i];
      #1;
      expect_out($sformatf("sym_%b", sym_in[i]), M_COMB,
                 (i < 3) ? 4'b1000 : 4'b0100);
    end

    #1;
    -> sample_ev;
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation still running at t=%0t, required finish", $time);
    $fatal(1);
  end

endmodule
